// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and
// default operand width / multiplier bits retired per cycle.
package seq_mult_pkg;

    localparam int STATE_W                = 2;
    localparam int DEFAULT_WIDTH          = 32;
    localparam int DEFAULT_BITS_PER_CYCLE = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mult_step.sv
// One shift-add step: adds BITS_PER_CYCLE shifted copies of |A| into the upper
// partial sum and returns the new upper sum plus the retired low bits.
module mult_step
    import seq_mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
    input  logic [WIDTH-1:0]          psum_i,
    input  logic [WIDTH-1:0]          mag_a_i,
    input  logic [BITS_PER_CYCLE-1:0] bits_i,
    output logic [WIDTH-1:0]          psum_o,
    output logic [BITS_PER_CYCLE-1:0] low_o
);

    localparam int SUM_W = WIDTH + BITS_PER_CYCLE;

    logic [SUM_W-1:0] sum_s;

    // Accumulate the selected partial products on top of the current upper sum
    always_comb begin
        sum_s = SUM_W'(psum_i);
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (bits_i[k]) begin
                sum_s = sum_s + (SUM_W'(mag_a_i) << k);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign psum_o = sum_s[SUM_W-1:BITS_PER_CYCLE];
    assign low_o  = sum_s[BITS_PER_CYCLE-1:0];

endmodule

// File: rtl/seq_mult_unit.sv
// Multi-cycle signed/unsigned multiplier with {HI,LO} result register.
// Define SEQ_MULT_ACC_EN to build the multiply-accumulate path driven by acc_en.
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic               acc_en,
    input  logic               flush,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]                step_psum_s;
    logic [BITS_PER_CYCLE-1:0]       step_low_s;
    logic [WIDTH+BITS_PER_CYCLE-1:0] lo_shift_s;
    logic [2*WIDTH-1:0]              product_s;
    logic [2*WIDTH-1:0]              fixed_s;
    logic [2*WIDTH-1:0]              result_next_s;

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .psum_i  (hi_q),
        .mag_a_i (mag_a_q),
        .bits_i  (lo_q[BITS_PER_CYCLE-1:0]),
        .psum_o  (step_psum_s),
        .low_o   (step_low_s)
    );

    // Retired product bits enter at the top of LO as the multiplier shifts out
    assign lo_shift_s = {step_low_s, lo_q} >> BITS_PER_CYCLE;
    assign product_s  = {hi_q, lo_q};
    assign fixed_s    = neg_q ? -product_s : product_s;

`ifdef SEQ_MULT_ACC_EN
    logic acc_q, acc_d;
    assign result_next_s = acc_q ? (result_q + fixed_s) : fixed_s;
`else
    logic unused_acc_s;
    assign unused_acc_s  = acc_en;
    assign result_next_s = fixed_s;
`endif

    // Next-state and datapath control; flush overrides everything else
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_a_d  = mag_a_q;
        neg_d    = neg_q;
        result_d = result_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SEQ_MULT_ACC_EN
        acc_d    = acc_q;
`endif
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CALC;
                        cnt_d   = '0;
                        hi_d    = '0;
                        mag_a_d = (signed_op && srcA[WIDTH-1]) ? -srcA : srcA;
                        lo_d    = (signed_op && srcB[WIDTH-1]) ? -srcB : srcB;
                        neg_d   = signed_op & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
`ifdef SEQ_MULT_ACC_EN
                        acc_d   = acc_en;
`endif
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                CALC: begin
                    hi_d = step_psum_s;
                    lo_d = lo_shift_s[WIDTH-1:0];
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                FIX: begin
                    state_d  = DONE;
                    result_d = result_next_s;
                    done_d   = 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_a_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_MULT_ACC_EN
            acc_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_a_q  <= mag_a_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_MULT_ACC_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_seq_mult_unit;

`ifdef SEQ_MULT_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, signed_op, acc_en, flush;
    logic [31:0] srcA, srcB;
    logic        ready, busy, done;
    logic [63:0] result;

    logic        rst4_n, start4, signed4, acc4, flush4;
    logic [31:0] a4, b4;
    logic        ready4, busy4, done4;
    logic [63:0] result4;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] model_res;

    seq_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .acc_en(acc_en), .flush(flush), .srcA(srcA), .srcB(srcB),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    seq_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .signed_op(signed4),
        .acc_en(acc4), .flush(flush4), .srcA(a4), .srcB(b4),
        .ready(ready4), .busy(busy4), .done(done4), .result(result4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
    endtask

    // Reference: plain integer multiply, optional accumulate modulo 2^64
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic acc,
                                            input logic [63:0] prev);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            ua = 64'(a);
            ub = 64'(b);
            p  = ua * ub;
        end
        if (acc && ACC_ON) p = p + prev;
        return p;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic acc, output logic [63:0] res, output int lat);
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready before start", 64'(ready), 64'd1);
        srcA = a; srcB = b; signed_op = sgn; acc_en = acc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c + 1;
                break;
            end
        end
        res = result;
        @(posedge clk); #1;
        check("done one cycle", 64'(done), 64'd0);
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] res, output int lat);
        check("dut4 ready", 64'(ready4), 64'd1);
        a4 = a; b4 = b; signed4 = sgn; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = c + 1;
                break;
            end
        end
        res = result4;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] res, exp;
        logic [31:0] ra, rb;
        logic        rs, rc;
        int          lat, dones;

        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; acc_en = 1'b0; flush = 1'b0;
        srcA = '0; srcB = '0;
        rst4_n = 1'b0; start4 = 1'b0; signed4 = 1'b0; acc4 = 1'b0; flush4 = 1'b0;
        a4 = '0; b4 = '0;

        vecs[0] = '{32'hFFFF_FFFD, 32'd5,        1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h8000_0000, 32'd1,        1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[4] = '{32'd0,         32'h1234_5678, 1'b0, 64'h0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
        vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};

        #12;
        check("reset result", result, 64'h0);
        check("reset ready", 64'(ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        // Release at a falling edge; the first op is accepted on the very next edge
        @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd34);
            model_res = vecs[i].exp;
        end

        // Accumulate sequence
        run_op(32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, res, lat);
        check("acc seed", res, 64'h0000_0000_FFFF_FFFF);
        run_op(32'd1, 32'd1, 1'b0, 1'b1, res, lat);
        exp = ACC_ON ? 64'h0000_0001_0000_0000 : 64'h0000_0000_0000_0001;
        check("acc result", res, exp);
        model_res = exp;

        // start during CALC is ignored
        srcA = 32'd6; srcB = 32'd7; signed_op = 1'b0; acc_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                start = 1'b1; srcA = 32'd100; srcB = 32'd100; signed_op = 1'b1; acc_en = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = c + 1;
                break;
            end
        end
        check("busy start ignored result", result, 64'd42);
        check("busy start ignored latency", 64'(lat), 64'd34);

        // start in the DONE cycle is ignored; accepted one cycle later
        start = 1'b1; srcA = 32'd3; srcB = 32'd3; signed_op = 1'b0; acc_en = 1'b0;
        @(posedge clk); #1;
        check("done-cycle start ready", 64'(ready), 64'd1);
        check("done-cycle start busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("accept after done busy", 64'(busy), 64'd1);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check("post-done op result", result, 64'd9);
        repeat (5) @(posedge clk);
        #1;
        check("result holds", result, 64'd9);
        model_res = 64'd9;

        // flush at cycle 5 of an operation
        srcA = 32'd5; srcB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush ready", 64'(ready), 64'd1);
        check("flush busy", 64'(busy), 64'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("flush no done", 64'(dones), 64'd0);
        check("flush result kept", result, 64'd9);

        // flush and start together: flush wins
        flush = 1'b1; start = 1'b1; srcA = 32'd2; srcB = 32'd2;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush+start ready", 64'(ready), 64'd1);
        check("flush+start busy", 64'(busy), 64'd0);
        check("flush+start result", result, 64'd9);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            exp = ref_mul(ra, rb, rs, rc, model_res);
            run_op(ra, rb, rs, rc, res, lat);
            check($sformatf("rand%0d %h*%h s%0d a%0d", i, ra, rb, rs, rc), res, exp);
            check($sformatf("rand%0d latency", i), 64'(lat), 64'd34);
            model_res = exp;
        end

        // Four multiplier bits per cycle
        run4(32'd7, 32'd9, 1'b0, res, lat);
        check("bpc4 7x9", res, 64'd63);
        check("bpc4 latency", 64'(lat), 64'd10);
        for (int i = 0; i < 12; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rs = 1'($urandom_range(0, 1));
            exp = ref_mul(ra, rb, rs, 1'b0, 64'h0);
            run4(ra, rb, rs, res, lat);
            check($sformatf("bpc4 rand%0d %h*%h s%0d", i, ra, rb, rs), res, exp);
            check($sformatf("bpc4 rand%0d latency", i), 64'(lat), 64'd10);
        end

        // Asynchronous reset in the middle of CALC
        a4 = 32'd11; b4 = 32'd13; signed4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst4_n = 1'b0;
        #1;
        check("bpc4 rst result", result4, 64'h0);
        check("bpc4 rst ready", 64'(ready4), 64'd1);
        check("bpc4 rst busy", 64'(busy4), 64'd0);
        check("bpc4 rst done", 64'(done4), 64'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        check("bpc4 rst no done", 64'(dones), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
